mem_stream_reader: RTL and testbench
====================================

// Module: mem_stream_reader
// PURPOSE
// Read-side engine for the single-port 24-bit sample RAM.
// Walks a programmed address window, issues reads, absorbs the RAM's
// one-cycle registered read latency, and presents words on a
// valid/ready stream to downstream audio/processing logic.
// Sustains one word per cycle under no backpressure; never drops or
// duplicates words under backpressure.
// PARAMETERS
// WORD_SIZE  24   data width; matches RAM word_size
// N_WORDS    512  RAM depth; need not be a power of 2
// AW         $clog2(N_WORDS)  address width (derived, do not override)
// PORTS
// clk        in   1          rising-edge clock
// rst_n      in   1          async active-low reset
// start      in   1          begin transfer; sampled in IDLE only
// base_addr  in   AW         first address; latched on accepted start
// length     in   AW+1       words to read, 0..N_WORDS; latched on start
// abort      in   1          cancel transfer; ignored in IDLE
// mem_a      out  AW         RAM address (RAM we tied 0 at top level)
// mem_dout   in   WORD_SIZE  RAM registered read data
// m_data     out  WORD_SIZE  stream data
// m_valid    out  1          stream valid
// m_ready    in   1          stream ready
// busy       out  1          high in RUN/DRAIN
// done       out  1          one-cycle completion pulse
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE, mem_a=0, m_data=0, m_valid=0,
//   busy=0, done=0, FIFO empty, in-flight flag cleared.
// - FSM: IDLE -start&len>0-> RUN -last addr issued-> DRAIN
//   -FIFO empty & nothing in flight-> IDLE (done=1 that cycle).
//   start&len==0 -> stay IDLE, done=1 next cycle, no data.
//   abort in RUN/DRAIN -> IDLE next cycle; FIFO flushed, in-flight
//   read discarded, m_valid=0, no done pulse.
// - start while busy is ignored; abort and start in same IDLE cycle:
//   start wins.
// - Read timing: start seen cycle 0 -> mem_a=base cycle 1 -> mem_dout
//   valid cycle 2 -> captured into FIFO -> m_valid=1, m_data=mem[base]
//   cycle 3.
// - 2-entry output FIFO. Issue a read in cycle t iff in RUN and
//   occ + inflight - pop < 2 (pop = m_valid&m_ready in t; inflight =
//   read issued in t-1). Guarantees no overflow and full rate.
// - Address steps +1; after N_WORDS-1 wraps to 0 (explicit compare).
// - m_data/m_valid held stable while m_valid&!m_ready.
// - done high exactly one cycle, the first IDLE cycle; busy low then.
// CONFIGURATION
// LOOP_RD_EN defined: adds input port loop (1 bit), latched on start.
//   loop=1: after final word address returns to base_addr and reading
//   continues indefinitely; DRAIN never entered, done never pulses;
//   only abort or rst_n ends it. loop=0: one-shot as above.
// LOOP_RD_EN undefined: no loop port; one-shot only.
// TESTING
// 1 mem[i]=3*i; start base=10 len=4, ready=1 -> m_data 30,33,36,39 on
//   cycles 3-6 back-to-back; done=1 cycle 7; busy 1-6.
// 2 same, m_ready=1,0,1,0... -> same 4 words in order, none dropped or
//   repeated; m_data stable while stalled; FIFO occ never >2.
// 3 base=510 len=4 (N_WORDS=512) -> mem_a 510,511,0,1; data 1530,
//   1533,0,3.
// 4 len=0 -> no m_valid; done=1 cycle 1. start during busy -> ignored.
// 5 base=0 len=8, abort after 2nd handshake -> m_valid=0 next cycle,
//   no done; new start base=100 len=2 -> exactly 300,303, no stale
//   word. Repeat with rst_n pulse mid-run -> all outputs at reset vals.
// 6 LOOP_RD_EN, loop=1 base=0 len=3 -> 0,3,6,0,3,6,... for 20 words,
//   done stays 0; abort -> idle.

Source files
------------

// File: rtl/mem_stream_reader.sv
// Read engine for the single-port sample RAM: walks an address window, absorbs the
// one-cycle registered read latency and streams words out through a 2-entry FIFO.
// Optional feature macro: LOOP_RD_EN (adds the 'loop' input for endless window replay).
module mem_stream_reader #(
  parameter int WORD_SIZE = 24,
  parameter int N_WORDS   = 512,
  localparam int AW       = $clog2(N_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [AW:0]          length,
  input  logic                 abort,
`ifdef LOOP_RD_EN
  input  logic                 loop,
`endif
  output logic [AW-1:0]        mem_a,
  input  logic [WORD_SIZE-1:0] mem_dout,
  output logic [WORD_SIZE-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [AW:0]          rem_q, rem_d;
  logic                 inflight_q, inflight_d;
  logic [1:0]           occ_q, occ_d;
  logic [WORD_SIZE-1:0] head_q, head_d, tail_q, tail_d;
  logic                 done_q, done_d;
  logic                 loop_q;
  logic                 pop, push, issue, last_issue, accept;
  logic [2:0]           occ_sum;

`ifdef LOOP_RD_EN
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_q <= 1'b0;
      base_q <= '0;
      len_q  <= '0;
    end else if (accept) begin
      loop_q <= loop;
      base_q <= base_addr;
      len_q  <= length;
    end
  end
`else
  assign loop_q = 1'b0;
`endif

  assign pop        = (occ_q != 2'd0) && m_ready;
  assign push       = inflight_q;
  assign accept     = (state_q == S_IDLE) && start && (length != '0);
  assign last_issue = issue && (rem_q == (AW+1)'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; DRAIN exits once the FIFO will be empty with no read pending
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) state_d = S_RUN;
          else              done_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (abort)                      state_d = S_IDLE;
        else if (last_issue && !loop_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (occ_d == 2'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / issue decode: a read is only issued if its word is guaranteed a FIFO slot
  always_comb begin
    busy    = (state_q != S_IDLE);
    occ_sum = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue   = (state_q == S_RUN) && !abort && (occ_sum < 3'd2);
  end

  always_comb begin
    addr_d     = addr_q;
    rem_d      = rem_q;
    inflight_d = issue;
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (accept) begin
      addr_d = base_addr;
      rem_d  = length;
    end else if (issue) begin
      if (last_issue && loop_q) begin
`ifdef LOOP_RD_EN
        addr_d = base_q;
        rem_d  = len_q;
`endif
      end else begin
        addr_d = (addr_q == AW'(N_WORDS - 1)) ? '0 : addr_q + AW'(1);
        rem_d  = rem_q - (AW+1)'(1);
      end
    end

    if (busy && abort) begin
      occ_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_d = mem_dout;
          else               tail_d = mem_dout;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd2) head_d = tail_q;
          occ_d = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_d = mem_dout;
          end else begin
            head_d = tail_q;
            tail_d = mem_dout;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      done_q     <= done_d;
    end
  end

  assign mem_a   = addr_q;
  assign m_data  = head_q;
  assign m_valid = (occ_q != 2'd0);
  assign done    = done_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader: cycle-exact vector table plus stream runs
// covering backpressure, address wrap, abort, reset mid-run and (with LOOP_RD_EN) looping.
module tb_mem_stream_reader;
  localparam int WS = 24;
  localparam int NW = 512;
  localparam int AW = 9;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, m_ready = 1'b1, loop = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [AW-1:0] mem_a;
  logic [WS-1:0] mem_dout = '0, m_data;
  logic          m_valid, busy, done;
  logic [WS-1:0] ram [NW];

  int checks = 0;
  int errors = 0;
  int done_cnt;
  logic [WS-1:0] got [$];
  logic [AW-1:0] addrs [$];
  int exp_w [$];

  typedef struct {
    bit            start;
    bit            abort;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    bit            exp_valid;
    bit            exp_busy;
    bit            exp_done;
    logic [WS-1:0] exp_data;
    bit            chk_a;
    logic [AW-1:0] exp_a;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  always #5 clk = ~clk;
  always @(posedge clk) mem_dout <= ram[mem_a];

  mem_stream_reader #(.WORD_SIZE(WS), .N_WORDS(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .abort     (abort),
`ifdef LOOP_RD_EN
    .loop      (loop),
`endif
    .mem_a     (mem_a),
    .mem_dout  (mem_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done)
  );

  function automatic vec_t mk(input int st, input int ab, input int b, input int l,
                              input int v, input int bz, input int d, input int data,
                              input int ca, input int a);
    vec_t r;
    r.start = bit'(st);  r.abort = bit'(ab);
    r.base = AW'(b);     r.len = (AW+1)'(l);
    r.exp_valid = bit'(v); r.exp_busy = bit'(bz); r.exp_done = bit'(d);
    r.exp_data = WS'(data); r.chk_a = bit'(ca); r.exp_a = AW'(a);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_words(input string tag);
    chk({tag, " word count"}, got.size(), exp_w.size());
    for (int i = 0; i < exp_w.size(); i++)
      if (i < got.size()) chk($sformatf("%s word %0d", tag, i), got[i], exp_w[i]);
  endtask

  // Starts a transfer and plays the downstream side, collecting accepted words.
  task automatic run_stream(input logic [AW-1:0] b, input logic [AW:0] l, input bit lp,
                            input bit toggle, input int abort_after, input int max_cycles,
                            input string tag);
    int            hs = 0;
    int            after_abort = 0;
    bit            abort_now = 1'b0;
    bit            aborted = 1'b0;
    bit            prev_stall = 1'b0;
    bit            finished = 1'b0;
    logic [WS-1:0] prev_data = '0;
    got.delete();
    addrs.delete();
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1; base_addr = b; length = l; loop = lp; m_ready = 1'b1; abort = 1'b0;
    for (int cyc = 1; cyc <= max_cycles && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc <= 4) addrs.push_back(mem_a);
      if (prev_stall) begin
        chk({tag, " stall valid"}, m_valid, 1);
        chk({tag, " stall data"}, m_data, prev_data);
      end
      if (aborted) begin
        chk({tag, " post-abort valid"}, m_valid, 0);
        chk({tag, " post-abort busy"}, busy, 0);
        chk({tag, " post-abort done"}, done, 0);
        after_abort++;
        if (after_abort == 3) finished = 1'b1;
      end
      abort = abort_now;
      if (abort_now) aborted = 1'b1;
      abort_now = 1'b0;
      m_ready = abort ? 1'b0 : (toggle ? bit'(cyc % 2) : 1'b1);
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        hs++;
        if (hs == abort_after) abort_now = 1'b1;
      end
      prev_stall = m_valid && !m_ready && !abort;
      prev_data  = m_data;
      if (done) begin
        done_cnt++;
        chk({tag, " busy at done"}, busy, 0);
        finished = 1'b1;
      end
    end
    chk({tag, " finished in budget"}, finished, 1);
    @(negedge clk);
    abort = 1'b0; m_ready = 1'b1; loop = 1'b0;
    $display("run %s: base=%0d len=%0d words=%0d done_pulses=%0d", tag, b, l, got.size(), done_cnt);
  endtask

  initial begin
    for (int i = 0; i < NW; i++) ram[i] = WS'(3 * i);

    //        st ab base len | v bz d data ca addr
    vecs[0]  = mk(1, 0,  10, 4,  0, 0, 0,  0, 1,  0);
    vecs[1]  = mk(0, 0,   0, 0,  0, 1, 0,  0, 1, 10);
    vecs[2]  = mk(0, 0,   0, 0,  0, 1, 0,  0, 1, 11);
    vecs[3]  = mk(1, 0, 200, 5,  1, 1, 0, 30, 1, 12);
    vecs[4]  = mk(0, 0,   0, 0,  1, 1, 0, 33, 1, 13);
    vecs[5]  = mk(0, 0,   0, 0,  1, 1, 0, 36, 1, 14);
    vecs[6]  = mk(0, 0,   0, 0,  1, 1, 0, 39, 1, 14);
    vecs[7]  = mk(0, 0,   0, 0,  0, 0, 1,  0, 1, 14);
    vecs[8]  = mk(1, 0,  50, 0,  0, 0, 0,  0, 1, 14);
    vecs[9]  = mk(0, 1,   0, 0,  0, 0, 1,  0, 0,  0);
    vecs[10] = mk(1, 1,  20, 1,  0, 0, 0,  0, 0,  0);
    vecs[11] = mk(0, 0,   0, 0,  0, 1, 0,  0, 1, 20);
    vecs[12] = mk(0, 0,   0, 0,  0, 1, 0,  0, 1, 21);
    vecs[13] = mk(0, 0,   0, 0,  1, 1, 0, 60, 1, 21);
    vecs[14] = mk(0, 0,   0, 0,  0, 0, 1,  0, 1, 21);
    vecs[15] = mk(0, 0,   0, 0,  0, 0, 0,  0, 1, 21);

    repeat (2) @(negedge clk);
    chk("reset m_valid", m_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset mem_a", mem_a, 0);
    chk("reset m_data", m_data, 0);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      chk($sformatf("vec%0d m_valid", k), m_valid, vecs[k].exp_valid);
      chk($sformatf("vec%0d busy", k), busy, vecs[k].exp_busy);
      chk($sformatf("vec%0d done", k), done, vecs[k].exp_done);
      if (vecs[k].exp_valid) chk($sformatf("vec%0d m_data", k), m_data, vecs[k].exp_data);
      if (vecs[k].chk_a) chk($sformatf("vec%0d mem_a", k), mem_a, vecs[k].exp_a);
      start = vecs[k].start; abort = vecs[k].abort;
      base_addr = vecs[k].base; length = vecs[k].len;
      $display("vec %0d: start=%0d abort=%0d valid=%0d data=%0d busy=%0d done=%0d",
               k, vecs[k].start, vecs[k].abort, m_valid, m_data, busy, done);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0;

    run_stream(10, 4, 1'b0, 1'b1, 0, 60, "backpressure");
    exp_w = '{30, 33, 36, 39};
    check_words("backpressure");
    chk("backpressure done pulses", done_cnt, 1);

    run_stream(510, 4, 1'b0, 1'b0, 0, 40, "wrap");
    exp_w = '{1530, 1533, 0, 3};
    check_words("wrap");
    chk("wrap addr count", addrs.size(), 4);
    if (addrs.size() == 4) begin
      chk("wrap addr0", addrs[0], 510);
      chk("wrap addr1", addrs[1], 511);
      chk("wrap addr2", addrs[2], 0);
      chk("wrap addr3", addrs[3], 1);
    end

    run_stream(0, 8, 1'b0, 1'b0, 2, 40, "abort");
    exp_w = '{0, 3};
    check_words("abort");
    chk("abort done pulses", done_cnt, 0);

    run_stream(100, 2, 1'b0, 1'b0, 0, 30, "after-abort");
    exp_w = '{300, 303};
    check_words("after-abort");
    chk("after-abort done pulses", done_cnt, 1);

    @(negedge clk);
    start = 1'b1; base_addr = 0; length = 8;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid-run valid before reset", m_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-run reset m_valid", m_valid, 0);
    chk("mid-run reset busy", busy, 0);
    chk("mid-run reset done", done, 0);
    chk("mid-run reset mem_a", mem_a, 0);
    chk("mid-run reset m_data", m_data, 0);
    @(negedge clk);
    chk("held reset m_valid", m_valid, 0);
    rst_n = 1'b1;
    $display("reset pulse applied mid-run");

    run_stream(100, 2, 1'b0, 1'b0, 0, 30, "after-reset");
    exp_w = '{300, 303};
    check_words("after-reset");
    chk("after-reset done pulses", done_cnt, 1);

`ifdef LOOP_RD_EN
    run_stream(0, 3, 1'b1, 1'b0, 20, 100, "loop");
    exp_w.delete();
    for (int i = 0; i < 20; i++) exp_w.push_back(3 * (i % 3));
    check_words("loop");
    chk("loop done pulses", done_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
